vxe_txnid_tracker: RTL and testbench
====================================

VXE_TXNID_TRACKER -- requirements
Module: vxe_txnid_tracker

Interface
REQ-001 Parameter: NTXN, default 64, number of allocatable transaction IDs (1..64); only IDs 0..NTXN-1 are ever issued.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_alloc_req  input  1  requester asks for a transaction ID this cycle.
REQ-005 i_alloc_rnw  input  1  direction of the transaction being allocated (1=read).
REQ-006 o_alloc_rdy  output  1  at least one ID is free.
REQ-007 o_alloc_txnid  output  6  ID granted when i_alloc_req && o_alloc_rdy.
REQ-008 i_res_vld  input  1  response status valid this cycle.
REQ-009 i_res_txnid  input  6  responding transaction ID.
REQ-010 i_res_rnw  input  1  responding transaction direction.
REQ-011 i_res_err  input  2  response error status; 2'b00 = OK, any other value = error.
REQ-012 o_outstanding  output  7  number of allocated, unretired IDs (0..64).
REQ-013 o_idle  output  1  o_outstanding == 0.
REQ-014 o_err_vld / o_err_txnid[5:0] / o_err_rnw / o_err_code[1:0]  output  first captured response error, sticky.
REQ-015 i_err_clr  input  1  clears the captured response error and the protocol error.
REQ-016 o_proto_err  output  1  sticky: response received for an ID that is not outstanding, is >= NTXN, or has a direction mismatch.

Function
REQ-017 Tracker SHALL hold one valid bit and one rnw bit per ID (NTXN entries).
REQ-018 o_alloc_txnid SHALL be, combinationally, the lowest-numbered ID whose valid bit is clear; o_alloc_rdy SHALL be high iff such an ID exists.
REQ-019 Allocation commits at the clock edge where i_alloc_req && o_alloc_rdy: valid bit set, rnw bit := i_alloc_rnw; i_alloc_req while !o_alloc_rdy SHALL have no effect.
REQ-020 Retire: on i_res_vld with an outstanding ID < NTXN, the valid bit SHALL clear at the next edge; the retired ID is allocatable from the following cycle.
REQ-021 Same-cycle allocate and retire: both commit; o_outstanding unchanged; the ID retired this cycle SHALL NOT be granted this cycle (grant uses pre-edge state).
REQ-022 o_outstanding SHALL be registered: +1 on allocate only, -1 on valid retire only, unchanged otherwise; it never wraps (bounded by NTXN and 0 by construction).
REQ-023 Response for an ID not outstanding or >= NTXN: state unchanged, o_proto_err set at next edge.
REQ-024 Response on an outstanding ID with i_res_rnw != stored rnw: ID still retired, o_proto_err set.
REQ-025 Valid retire with i_res_err != 0 and o_err_vld low: capture ID, rnw, code; o_err_vld high from next cycle; later errors are dropped while o_err_vld is high.
REQ-026 i_err_clr clears o_err_vld and o_proto_err at the next edge; a new error or protocol violation in the same cycle as i_err_clr SHALL win (flag set, new values captured).
REQ-027 Errors SHALL NOT block retirement or allocation.

Reset
REQ-028 On rst: all valid and rnw bits 0, o_outstanding 0, o_idle 1, o_alloc_rdy 1, o_alloc_txnid 0, o_err_vld 0, o_err_txnid 0, o_err_rnw 0, o_err_code 0, o_proto_err 0.
REQ-029 Reset mid-operation SHALL discard all outstanding IDs; responses after reset for pre-reset IDs raise o_proto_err.

Structure
REQ-030 Shared package vxe_txn_pkg SHALL hold TXNID_W=6, ERR_W=2, ERR_OK=2'b00, and MAX_TXN=64.
REQ-031 Lowest-free-ID search SHALL be a sub-module vxe_txnid_penc (NTXN-bit vector in, 6-bit index plus found flag out).

Verification
REQ-032 Reset, then alloc 3 consecutive cycles rnw=1,0,1 -> IDs 0,1,2 granted, o_outstanding=3, o_idle=0.
REQ-033 NTXN=64, 64 allocs -> o_alloc_rdy=0 with o_outstanding=64; retire ID 17 -> next cycle o_alloc_rdy=1, o_alloc_txnid=17.
REQ-034 Outstanding ID 5, alloc and retire 5 same cycle with IDs 0..4 valid -> grant ID 6, o_outstanding unchanged, ID 5 free next cycle.
REQ-035 Retire ID 3 err=2'b10 then ID 4 err=2'b01 -> o_err_txnid=3, o_err_code=2'b10 held; i_err_clr with ID 4 err=2'b11 same cycle -> o_err_vld=1, txnid=4, code=2'b11.
REQ-036 Response for free ID 9, then read ID 2 answered with rnw=0 -> o_proto_err=1, ID 2 retired, o_outstanding decremented by 1.
REQ-037 Assert rst with 10 outstanding -> same cycle o_outstanding=0, o_idle=1, o_alloc_txnid=0.

Source files
------------

// File: rtl/vxe_txn_pkg.sv
// Shared widths, limits and the captured-error record for the transaction ID tracker.
// Widths follow the 64-entry ID space; error code 2'b00 means OK.
package vxe_txn_pkg;

  localparam int TXNID_W = 6;
  localparam int ERR_W   = 2;
  localparam int MAX_TXN = 64;
  localparam int CNT_W   = 7;

  localparam logic [ERR_W-1:0] ERR_OK = 2'b00;

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic               rnw;
    logic [ERR_W-1:0]   code;
  } err_rec_t;

  function automatic logic is_err(input logic [ERR_W-1:0] code);
    return code != ERR_OK;
  endfunction

endpackage

// File: rtl/vxe_txnid_penc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit of vec
// and a found flag; idx is 0 when nothing is set.
module vxe_txnid_penc
  import vxe_txn_pkg::*;
#(
  parameter int N = MAX_TXN
) (
  input  logic [N-1:0]       vec,
  output logic [TXNID_W-1:0] idx,
  output logic               found
);

  // NOTE: outputs get a default before the loop so every path assigns them;
  // without it an unmatched search would hold the old value and infer a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan high to low so the last hit written is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = TXNID_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vxe_txnid_tracker.sv
// Transaction ID tracker: grants the lowest free ID, retires IDs on responses,
// counts outstanding IDs and records the first response error and protocol violations.
module vxe_txnid_tracker
  import vxe_txn_pkg::*;
#(
  parameter int NTXN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc_req,
  input  logic               i_alloc_rnw,
  output logic               o_alloc_rdy,
  output logic [TXNID_W-1:0] o_alloc_txnid,
  input  logic               i_res_vld,
  input  logic [TXNID_W-1:0] i_res_txnid,
  input  logic               i_res_rnw,
  input  logic [ERR_W-1:0]   i_res_err,
  output logic [CNT_W-1:0]   o_outstanding,
  output logic               o_idle,
  output logic               o_err_vld,
  output logic [TXNID_W-1:0] o_err_txnid,
  output logic               o_err_rnw,
  output logic [ERR_W-1:0]   o_err_code,
  input  logic               i_err_clr,
  output logic               o_proto_err
);

  logic [NTXN-1:0]    valid_q, valid_d;
  logic [NTXN-1:0]    rnw_q, rnw_d;
  logic [NTXN-1:0]    alloc_mask, retire_mask;
  logic [MAX_TXN-1:0] valid_ext, rnw_ext;
  logic [MAX_TXN-1:0] alloc_oh, res_oh;

  logic               alloc_fire;
  logic               res_hit, rnw_mismatch;
  logic               retire, proto_viol;
  logic               err_capture;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_vld_q;
  err_rec_t           err_q;
  logic               proto_q;

  vxe_txnid_penc #(
    .N (NTXN)
  ) u_penc (
    .vec   (~valid_q),
    .idx   (o_alloc_txnid),
    .found (o_alloc_rdy)
  );

  // Widening to the full ID space makes IDs >= NTXN read as not outstanding.
  assign valid_ext = MAX_TXN'(valid_q);
  assign rnw_ext   = MAX_TXN'(rnw_q);
  assign alloc_oh  = MAX_TXN'(1) << o_alloc_txnid;
  assign res_oh    = MAX_TXN'(1) << i_res_txnid;

  assign alloc_fire   = i_alloc_req && o_alloc_rdy;
  assign res_hit      = valid_ext[i_res_txnid];
  assign rnw_mismatch = rnw_ext[i_res_txnid] != i_res_rnw;
  assign retire       = i_res_vld && res_hit;
  assign proto_viol   = i_res_vld && (!res_hit || rnw_mismatch);
  assign err_capture  = retire && is_err(i_res_err) && (!err_vld_q || i_err_clr);

  assign alloc_mask  = alloc_fire ? alloc_oh[NTXN-1:0] : '0;
  assign retire_mask = retire     ? res_oh[NTXN-1:0]   : '0;

  // The granted ID is free and the retired ID is valid, so the masks never overlap.
  assign valid_d = (valid_q & ~retire_mask) | alloc_mask;
  assign rnw_d   = (rnw_q & ~alloc_mask) | (i_alloc_rnw ? alloc_mask : '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({alloc_fire, retire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: the per-ID valid bits are reset because they define which IDs are
  // outstanding; leaving them unreset would hand out or retire garbage IDs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rnw_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rnw_q   <= rnw_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new error or violation in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vld_q <= 1'b0;
      err_q     <= '0;
      proto_q   <= 1'b0;
    end else begin
      if (err_capture) begin
        err_vld_q <= 1'b1;
        err_q     <= '{txnid: i_res_txnid, rnw: i_res_rnw, code: i_res_err};
      end else if (i_err_clr) begin
        err_vld_q <= 1'b0;
      end

      if (proto_viol) begin
        proto_q <= 1'b1;
      end else if (i_err_clr) begin
        proto_q <= 1'b0;
      end
    end
  end

  assign o_outstanding = cnt_q;
  assign o_idle        = (cnt_q == '0);
  assign o_err_vld     = err_vld_q;
  assign o_err_txnid   = err_q.txnid;
  assign o_err_rnw     = err_q.rnw;
  assign o_err_code    = err_q.code;
  assign o_proto_err   = proto_q;

endmodule

// File: tb/tb_vxe_txnid_tracker.sv
// Directed bench for vxe_txnid_tracker (NTXN=64): allocation order, full/empty,
// same-cycle alloc+retire, error capture/clear priority, protocol errors, async reset.
module tb_vxe_txnid_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_alloc_req = 1'b0;
  logic       i_alloc_rnw = 1'b0;
  logic       o_alloc_rdy;
  logic [5:0] o_alloc_txnid;
  logic       i_res_vld = 1'b0;
  logic [5:0] i_res_txnid = '0;
  logic       i_res_rnw = 1'b0;
  logic [1:0] i_res_err = '0;
  logic [6:0] o_outstanding;
  logic       o_idle;
  logic       o_err_vld;
  logic [5:0] o_err_txnid;
  logic       o_err_rnw;
  logic [1:0] o_err_code;
  logic       i_err_clr = 1'b0;
  logic       o_proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  vxe_txnid_tracker #(.NTXN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_alloc_req   (i_alloc_req),
    .i_alloc_rnw   (i_alloc_rnw),
    .o_alloc_rdy   (o_alloc_rdy),
    .o_alloc_txnid (o_alloc_txnid),
    .i_res_vld     (i_res_vld),
    .i_res_txnid   (i_res_txnid),
    .i_res_rnw     (i_res_rnw),
    .i_res_err     (i_res_err),
    .o_outstanding (o_outstanding),
    .o_idle        (o_idle),
    .o_err_vld     (o_err_vld),
    .o_err_txnid   (o_err_txnid),
    .o_err_rnw     (o_err_rnw),
    .o_err_code    (o_err_code),
    .i_err_clr     (i_err_clr),
    .o_proto_err   (o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge; inputs are then changed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_alloc_req = 1'b0;
    i_alloc_rnw = 1'b0;
    i_res_vld   = 1'b0;
    i_res_txnid = '0;
    i_res_rnw   = 1'b0;
    i_res_err   = '0;
    i_err_clr   = 1'b0;
  endtask

  // Allocate with direction rnw, checking the ID offered before the edge.
  task automatic do_alloc(input logic rnw, input logic [5:0] exp_id, input string tag);
    i_alloc_req = 1'b1;
    i_alloc_rnw = rnw;
    #1;
    check(tag, o_alloc_txnid, exp_id);
    tick();
    idle_inputs();
  endtask

  task automatic do_resp(input logic [5:0] id, input logic rnw, input logic [1:0] err, input logic clr);
    i_res_vld   = 1'b1;
    i_res_txnid = id;
    i_res_rnw   = rnw;
    i_res_err   = err;
    i_err_clr   = clr;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    repeat (2) tick();
    check("rst_outstanding", o_outstanding, 0);
    check("rst_idle",        o_idle,        1);
    check("rst_rdy",         o_alloc_rdy,   1);
    check("rst_txnid",       o_alloc_txnid, 0);
    check("rst_err_vld",     o_err_vld,     0);
    check("rst_err_txnid",   o_err_txnid,   0);
    check("rst_err_rnw",     o_err_rnw,     0);
    check("rst_err_code",    o_err_code,    0);
    check("rst_proto",       o_proto_err,   0);
    rst = 1'b0;
    tick();

    // Three back-to-back allocations: IDs 0,1,2 with rnw 1,0,1.
    do_alloc(1'b1, 6'd0, "alloc_id0");
    do_alloc(1'b0, 6'd1, "alloc_id1");
    do_alloc(1'b1, 6'd2, "alloc_id2");
    check("out_after3", o_outstanding, 3);
    check("idle_after3", o_idle, 0);

    // Fill the remaining 61 IDs as writes.
    for (int i = 3; i < 64; i++) do_alloc(1'b0, 6'(i), "alloc_fill");
    check("full_rdy", o_alloc_rdy, 0);
    check("full_out", o_outstanding, 64);

    // Request while full has no effect.
    i_alloc_req = 1'b1;
    tick();
    idle_inputs();
    check("full_req_out", o_outstanding, 64);
    check("full_req_rdy", o_alloc_rdy, 0);

    // Retire 17: allocatable next cycle.
    do_resp(6'd17, 1'b0, 2'b00, 1'b0);
    check("ret17_rdy", o_alloc_rdy, 1);
    check("ret17_txnid", o_alloc_txnid, 17);
    check("ret17_out", o_outstanding, 63);
    check("ret17_proto", o_proto_err, 0);

    // Free 6, then allocate (grant 6) and retire 5 in the same cycle.
    do_resp(6'd6, 1'b0, 2'b00, 1'b0);
    check("ret6_txnid", o_alloc_txnid, 6);
    i_alloc_req = 1'b1;
    i_alloc_rnw = 1'b1;
    i_res_vld   = 1'b1;
    i_res_txnid = 6'd5;
    i_res_rnw   = 1'b0;
    #1;
    check("same_grant", o_alloc_txnid, 6);
    tick();
    idle_inputs();
    check("same_out", o_outstanding, 62);
    check("same_next", o_alloc_txnid, 5);
    check("same_proto", o_proto_err, 0);

    // First error is captured and held; later error dropped.
    do_resp(6'd3, 1'b0, 2'b10, 1'b0);
    check("err1_vld", o_err_vld, 1);
    check("err1_txnid", o_err_txnid, 3);
    check("err1_code", o_err_code, 2);
    check("err1_rnw", o_err_rnw, 0);
    do_resp(6'd4, 1'b0, 2'b01, 1'b0);
    check("err2_txnid", o_err_txnid, 3);
    check("err2_code", o_err_code, 2);
    check("err2_out", o_outstanding, 60);

    // Reallocate 3 and 4 as reads; error on 4 alongside a clear wins.
    do_alloc(1'b1, 6'd3, "realloc3");
    do_alloc(1'b1, 6'd4, "realloc4");
    do_resp(6'd4, 1'b1, 2'b11, 1'b1);
    check("clrwin_vld", o_err_vld, 1);
    check("clrwin_txnid", o_err_txnid, 4);
    check("clrwin_code", o_err_code, 3);
    check("clrwin_rnw", o_err_rnw, 1);
    check("clrwin_out", o_outstanding, 61);
    i_err_clr = 1'b1;
    tick();
    idle_inputs();
    check("clr_vld", o_err_vld, 0);

    // Response for a free ID flags a protocol error and changes nothing.
    do_resp(6'd9, 1'b0, 2'b00, 1'b0);
    check("ret9_out", o_outstanding, 60);
    check("ret9_proto", o_proto_err, 0);
    do_resp(6'd9, 1'b0, 2'b00, 1'b0);
    check("free9_proto", o_proto_err, 1);
    check("free9_out", o_outstanding, 60);
    // Violation in the clearing cycle keeps the flag set.
    do_resp(6'd9, 1'b0, 2'b00, 1'b1);
    check("proto_clrwin", o_proto_err, 1);
    i_err_clr = 1'b1;
    tick();
    idle_inputs();
    check("proto_clr", o_proto_err, 0);

    // Read ID 2 answered as a write: retired anyway, flag set.
    do_resp(6'd2, 1'b0, 2'b00, 1'b0);
    check("dir_proto", o_proto_err, 1);
    check("dir_out", o_outstanding, 59);
    check("dir_txnid", o_alloc_txnid, 2);

    // Async reset mid-operation, observed before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", o_outstanding, 0);
    check("arst_idle", o_idle, 1);
    check("arst_txnid", o_alloc_txnid, 0);
    check("arst_rdy", o_alloc_rdy, 1);
    check("arst_proto", o_proto_err, 0);
    tick();
    rst = 1'b0;
    tick();
    // Response for a pre-reset ID is now a protocol error.
    do_resp(6'd6, 1'b1, 2'b00, 1'b0);
    check("post_rst_proto", o_proto_err, 1);
    check("post_rst_out", o_outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
